div_share_arbiter: RTL

Round-robin front end that shares one fixed-latency 16-bit unsigned divider among `N_REQ` requesters. It accepts one division request at a time over per-requester valid/ready handshakes and drives the divider operands. It waits out the divider latency, then returns the quotient with the winning requester's ID over a single valid/ready response port. It sits between the requesting datapath blocks and the shared divider instance.

---
 rtl/div_share_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/div_share_arbiter.sv
//==============================================================================
// Module      : div_share_arbiter
// Description : Round-robin front end sharing one fixed-latency 16-bit unsigned
//               divider among N_REQ requesters. Optional macro
//               DIV_SHARE_ZERO_CHECK_EN short-circuits zero divisors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_share_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int DIV_LATENCY = 1,
    localparam int ID_W        = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_u,
    input  logic [16*N_REQ-1:0]   req_v,
    output logic [15:0]           div_u,
    output logic [15:0]           div_v,
    output logic                  div_start,
    input  logic [15:0]           div_q,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_q,
    output logic                  resp_dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_lat = 4'(DIV_LATENCY);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [3:0]      r_cnt;
    logic [15:0]     r_div_u;
    logic [15:0]     r_div_v;
    logic            r_start;
    logic            r_valid;
    logic [ID_W-1:0] r_id;
    logic [15:0]     r_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
    logic            r_dz;
`endif

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [15:0]     w_u;
    logic [15:0]     w_v;

    // Search upward from the pointer, wrapping, for the first valid request.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_u = '0;
        w_v = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win == ID_W'(k)) begin
                w_u = req_u[16*k +: 16];
                w_v = req_v[16*k +: 16];
            end
        end
    end

    assign w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_div_u <= '0;
            r_div_v <= '0;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_q     <= '0;
`ifdef DIV_SHARE_ZERO_CHECK_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id  <= w_win;
                        r_ptr <= w_ptr_nxt;
`ifdef DIV_SHARE_ZERO_CHECK_EN
                        // Zero divisor bypasses the divider entirely.
                        if (w_v == 16'd0) begin
                            r_q     <= 16'hFFFF;
                            r_dz    <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_RESP;
                        end else
`endif
                        begin
                            r_div_u <= w_u;
                            r_div_v <= w_v;
                            r_cnt   <= c_lat;
                            r_start <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_q     <= div_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
                        r_dz    <= 1'b0;
`endif
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_u      = r_div_u;
    assign div_v      = r_div_v;
    assign div_start  = r_start;
    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_q     = r_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
    assign resp_dz    = r_dz;
`else
    assign resp_dz    = 1'b0;
`endif

endmodule

`default_nettype wire
